// File: rtl/b01_serial_driver.sv
// +----------------------------------------------------------------------------+
// | Module      : b01_serial_driver                                            |
// | Description : Serialises an operand pair LSB-first onto LINE1/LINE2 and    |
// |               reassembles the returned adder bit stream plus a sticky      |
// |               overflow flag. Optional macro B01_DRV_CHECK_EN adds an       |
// |               on-line result checker driving the mismatch output.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module b01_serial_driver #(
  parameter int WIDTH  = 8,
  parameter int RX_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             LINE1,
  output logic             LINE2,
  input  logic             outp_in,
  input  logic             ovf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
`ifdef B01_DRV_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int c_cnt_w = $clog2(WIDTH + RX_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_width_m1 = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_lat_m1   = c_cnt_w'((RX_LAT > 0) ? RX_LAT - 1 : 0);
  localparam logic [c_cnt_w:0]   c_width_x  = (c_cnt_w + 1)'(WIDTH);
  localparam logic [c_cnt_w:0]   c_lat_x    = (c_cnt_w + 1)'(RX_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  logic [c_cnt_w:0]   w_elapsed;
  logic               w_sample;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic               w_ovf_nxt;
  logic               w_accept;
  logic               w_shift_last;
  logic               w_drain_last;
  logic               w_enter_hold;
  logic               w_result_taken;

  // Cycles since the first bit went out; the result bit for bit k arrives at k+RX_LAT.
  always_comb begin
    w_elapsed = '0;
    if (r_state == S_SHIFT) begin
      w_elapsed = {1'b0, r_cnt};
    end else if (r_state == S_DRAIN) begin
      w_elapsed = {1'b0, r_cnt} + c_width_x;
    end
  end

  assign w_sample       = ((r_state == S_SHIFT) || (r_state == S_DRAIN)) && (w_elapsed >= c_lat_x);
  assign w_sum_nxt      = w_sample ? {outp_in, sum[WIDTH-1:1]} : sum;
  assign w_ovf_nxt      = ovf | (w_sample & ovf_in);
  assign w_accept       = (r_state == S_IDLE) && in_valid && in_ready;
  assign w_shift_last   = (r_state == S_SHIFT) && (r_cnt == c_width_m1);
  assign w_drain_last   = (r_state == S_DRAIN) && (r_cnt == c_lat_m1);
  assign w_enter_hold   = (w_shift_last && (RX_LAT == 0)) || w_drain_last;
  assign w_result_taken = (r_state == S_HOLD) && out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      in_ready  <= 1'b0;
      LINE1     <= 1'b0;
      LINE2     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            in_ready <= 1'b0;
            LINE1    <= op_a[0];
            LINE2    <= op_b[0];
            r_a      <= op_a >> 1;
            r_b      <= op_b >> 1;
            sum      <= '0;
            ovf      <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sum <= w_sum_nxt;
          ovf <= w_ovf_nxt;
          if (w_shift_last) begin
            LINE1 <= 1'b0;
            LINE2 <= 1'b0;
            r_cnt <= '0;
            if (w_enter_hold) begin
              out_valid <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_state   <= S_DRAIN;
            end
          end else begin
            LINE1 <= r_a[0];
            LINE2 <= r_b[0];
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          sum <= w_sum_nxt;
          ovf <= w_ovf_nxt;
          if (w_drain_last) begin
            r_cnt     <= '0;
            out_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          // in_ready rises on the exit edge, so IDLE always lasts at least one cycle.
          if (w_result_taken) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            sum       <= '0;
            ovf       <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef B01_DRV_CHECK_EN
  logic [WIDTH-1:0] r_exp;
  logic             r_carry;

  // The final sample lands on the same edge that enters HOLD, so compare the next values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_exp    <= '0;
      r_carry  <= 1'b0;
      mismatch <= 1'b0;
    end else if (w_accept) begin
      {r_carry, r_exp} <= {1'b0, op_a} + {1'b0, op_b};
      mismatch         <= 1'b0;
    end else if (w_enter_hold) begin
      mismatch <= (w_sum_nxt != r_exp) || (w_ovf_nxt != r_carry);
    end else if (w_result_taken) begin
      mismatch <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_b01_serial_driver.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_b01_serial_driver                                         |
// | Description : Directed bench for b01_serial_driver with a behavioural      |
// |               one-cycle serial-adder loopback (define B01_DRV_CHECK_EN to  |
// |               also cover the mismatch output).                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_b01_serial_driver;

  localparam int WIDTH = 8;
  localparam logic [3:0] LB_LAST = 4'd7;
  localparam logic [3:0] NO_FLIP = 4'hF;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             LINE1;
  logic             LINE2;
  logic             outp_in = 1'b0;
  logic             ovf_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             ovf;
`ifdef B01_DRV_CHECK_EN
  logic             mismatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  b01_serial_driver #(.WIDTH(WIDTH), .RX_LAT(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .LINE1     (LINE1),
    .LINE2     (LINE2),
    .outp_in   (outp_in),
    .ovf_in    (ovf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
`ifdef B01_DRV_CHECK_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  // Serial adder with registered OUTP/OVERFLW; flip_bit inverts one result bit.
  logic [3:0] lb_pos = 4'd0;
  logic       lb_carry = 1'b0;
  logic [3:0] flip_bit = NO_FLIP;
  logic       lb_clear;
  logic       lb_cout;
  assign lb_clear = in_valid & in_ready;
  assign lb_cout  = (LINE1 & LINE2) | (LINE1 & lb_carry) | (LINE2 & lb_carry);

  always @(posedge clock) begin
    if (reset || lb_clear) begin
      lb_pos   <= 4'd0;
      lb_carry <= 1'b0;
      outp_in  <= 1'b0;
      ovf_in   <= 1'b0;
    end else if (lb_pos <= LB_LAST) begin
      outp_in  <= LINE1 ^ LINE2 ^ lb_carry ^ (lb_pos == flip_bit);
      lb_carry <= lb_cout;
      ovf_in   <= (lb_pos == LB_LAST) && lb_cout;
      lb_pos   <= lb_pos + 4'd1;
    end else begin
      outp_in <= 1'b0;
      ovf_in  <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns in the first HOLD cycle (or after the bound); lat counts cycles after the accept edge.
  task automatic run_word(input logic [7:0] a, input logic [7:0] b, input logic [3:0] flip,
                          output logic [7:0] l1, output logic [7:0] l2, output int lat);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_word", 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    flip_bit = flip;
    in_valid = 1'b1;
    tick();
    // Keep in_valid high with different operands: both must be ignored outside IDLE.
    op_a = ~a;
    op_b = ~b;
    lat  = 1;
    for (int j = 0; j < 8; j++) begin
      l1[j] = LINE1;
      l2[j] = LINE2;
      if (j < 7) begin
        tick();
        lat++;
      end
    end
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] flip;
    logic [7:0] exp_sum;
    logic       exp_ovf;
    logic       exp_mm;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] l1;
  logic [7:0] l2;
  int         lat;
  int         seen;

  initial begin
    vecs[0] = '{8'h35, 8'h0A, NO_FLIP, 8'h3F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, NO_FLIP, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 4'd3,    8'h19, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, NO_FLIP, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, NO_FLIP, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, NO_FLIP, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 8'h5A, NO_FLIP, 8'h1D, 1'b1, 1'b0};

    // Reset held for three edges.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_line1", 32'(LINE1), 32'd0);
      check("rst_line2", 32'(LINE2), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      if (i < 2) tick();
    end
    reset = 1'b0;
    tick();
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      run_word(vecs[v].a, vecs[v].b, vecs[v].flip, l1, l2, lat);
      check("latency", 32'(lat), 32'd10);
      check("line1_bits", 32'(l1), 32'(vecs[v].a));
      check("line2_bits", 32'(l2), 32'(vecs[v].b));
      check("sum", 32'(sum), 32'(vecs[v].exp_sum));
      check("ovf", 32'(ovf), 32'(vecs[v].exp_ovf));
      check("in_ready_in_hold", 32'(in_ready), 32'd0);
`ifdef B01_DRV_CHECK_EN
      check("mismatch", 32'(mismatch), 32'(vecs[v].exp_mm));
`endif
      finish_word();
    end

    // Host stalls the result for five cycles.
    run_word(8'h5A, 8'h0F, NO_FLIP, l1, l2, lat);
    check("stall_latency", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'h69);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    finish_word();

    // Reset while bit 4 is on the line.
    op_a     = 8'hFF;
    op_b     = 8'hFF;
    flip_bit = NO_FLIP;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_line1_bit4", 32'(LINE1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_line1", 32'(LINE1), 32'd0);
    check("mid_rst_line2", 32'(LINE2), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    check("mid_rst_no_partial", 32'(seen), 32'd0);
    check("mid_rst_in_ready_idle", 32'(in_ready), 32'd1);
    run_word(8'h01, 8'h01, NO_FLIP, l1, l2, lat);
    check("post_rst_latency", 32'(lat), 32'd10);
    check("post_rst_sum", 32'(sum), 32'h02);
    check("post_rst_ovf", 32'(ovf), 32'd0);
    finish_word();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
